// File: rtl/rotsq_pkg.sv
// Shared constants and types for the rotating square animation.
package rotsq_pkg;
  localparam int NUM_POS = 8;

  typedef logic [2:0] pos_t;
  typedef logic [6:0] seg_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam seg_t SEG_UPPER = 7'h1C;
  localparam seg_t SEG_LOWER = 7'h23;
  localparam seg_t SEG_BLANK = 7'h7F;
endpackage

// File: rtl/tick_generator.sv
// Free-running N-bit prescaler; tick_o flags the cycle the count wraps while enabled.
module tick_generator #(
  parameter int N = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)     cnt <= '0;
    else if (en_i) cnt <= cnt + ONE;
  end

  // Combinational strobe so the consumer can register its own state on this very edge.
  assign tick_o = en_i && (cnt == '1);
endmodule

// File: rtl/rotating_square_controller.sv
// Steps a square glyph around an 8-position loop on a 4-digit seven-segment display.
// Optional manual single-step input enabled by defining ROTSQ_STEP_EN.
module rotating_square_controller
  import rotsq_pkg::*;
#(
  parameter int N = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic cw_i,
`ifdef ROTSQ_STEP_EN
  input  logic step_i,
`endif
  output seg_t in0_o,
  output seg_t in1_o,
  output seg_t in2_o,
  output seg_t in3_o,
  output pos_t pos_o,
  output logic tick_o
);
  logic presc_tick;
  logic manual;
  logic advance;
  pos_t pos;
  seg_t [3:0] digit;

  tick_generator #(.N(N)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .tick_o (presc_tick)
  );

`ifdef ROTSQ_STEP_EN
  logic step_q, step_qq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q  <= 1'b0;
      step_qq <= 1'b0;
    end else begin
      step_q  <= step_i;
      step_qq <= step_q;
    end
  end

  // Manual steps only count while the prescaler is paused.
  assign manual = step_q & ~step_qq & ~en_i;
`else
  assign manual = 1'b0;
`endif

  assign advance = presc_tick | manual;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos    <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= advance;
      if (advance) pos <= cw_i ? pos + 3'd1 : pos - 3'd1;
    end
  end

  // Upper half runs digit 3..0 at pos 0..3; lower half returns digit 0..3 at pos 4..7.
  always_comb begin
    digit = {4{SEG_BLANK}};
    if (pos[2]) digit[pos[1:0]]         = SEG_LOWER;
    else        digit[2'd3 - pos[1:0]]  = SEG_UPPER;
  end

  assign in0_o = digit[0];
  assign in1_o = digit[1];
  assign in2_o = digit[2];
  assign in3_o = digit[3];
  assign pos_o = pos;
endmodule

// File: tb/tb_rotating_square_controller.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_rotating_square_controller;
  localparam int N = 3;
  localparam int PERIOD = 1 << N;

  typedef struct {
    int         pos;
    bit         tick;
    logic [6:0] d0, d1, d2, d3;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic cw  = 1'b1;
  logic [6:0] in0, in1, in2, in3;
  logic [2:0] pos;
  logic tick;

  int compared = 0;
  int mism     = 0;
  exp_t exp_q[$];

  // Reference state: prescaler count and loop position as plain integers.
  int m_cnt = 0;
  int m_pos = 0;

  always #5 clk = ~clk;

  rotating_square_controller #(.N(N)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .cw_i   (cw),
`ifdef ROTSQ_STEP_EN
    .step_i (1'b0),
`endif
    .in0_o  (in0),
    .in1_o  (in1),
    .in2_o  (in2),
    .in3_o  (in3),
    .pos_o  (pos),
    .tick_o (tick)
  );

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mism++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply inputs for the next edge and push what the outputs must show after it.
  task automatic drive(input bit r, input bit e, input bit c);
    exp_t x;
    logic [6:0] d[4];
    @(negedge clk);
    rst = r; en = e; cw = c;
    x.tick = 0;
    if (r) begin
      m_cnt = 0;
      m_pos = 0;
    end else if (e) begin
      if (m_cnt == PERIOD - 1) begin
        x.tick = 1;
        m_pos  = c ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
    for (int i = 0; i < 4; i++) d[i] = 7'h7F;
    if (m_pos < 4) d[3 - m_pos] = 7'h1C;
    else           d[m_pos - 4] = 7'h23;
    x.pos = m_pos;
    x.d0 = d[0]; x.d1 = d[1]; x.d2 = d[2]; x.d3 = d[3];
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t e;
    int lit;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pos",  int'(pos),  e.pos);
      chk("tick", int'(tick), int'(e.tick));
      chk("in0",  int'(in0),  int'(e.d0));
      chk("in1",  int'(in1),  int'(e.d1));
      chk("in2",  int'(in2),  int'(e.d2));
      chk("in3",  int'(in3),  int'(e.d3));
      lit = int'(in0 != 7'h7F) + int'(in1 != 7'h7F) + int'(in2 != 7'h7F) + int'(in3 != 7'h7F);
      chk("one_lit", lit, 1);
    end
  end

  initial begin
    // Clockwise run from reset.
    drive(1, 0, 1);
    drive(1, 1, 1);
    for (int i = 0; i < 80; i++) drive(0, 1, 1);

    // Counter-clockwise from reset: 7, 6, 5.
    drive(1, 1, 0);
    for (int i = 0; i < 30; i++) drive(0, 1, 0);

    // Pause mid-count at counter 5, then resume.
    drive(1, 1, 1);
    for (int i = 0; i < 5; i++) drive(0, 1, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 1);
    for (int i = 0; i < 12; i++) drive(0, 1, 1);

    // Flip direction the cycle right after a step.
    for (int i = 0; i < 40; i++) begin
      bit flip;
      flip = (m_cnt == 0) && ($urandom_range(0, 1) == 1);
      drive(0, 1, flip ? ~cw : cw);
    end

    // Reset at pos 6 with counter 7 while enabled, then observe the first tick.
    for (int i = 0; i < 200 && !(m_pos == 6 && m_cnt == 7); i++) drive(0, 1, 1);
    drive(1, 1, 1);
    for (int i = 0; i < 12; i++) drive(0, 1, 1);

    // Random traffic with occasional pauses and resets.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    @(posedge clk);
    #5;
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
